// File: rtl/frame_read_addr_gen.sv
// Frame read address generator: issues one DRAM read per frame word,
// bounds in-flight reads and tracks returning responses to frame end.
module frame_read_addr_gen #(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned NUM_WORDS       = 115200,
  parameter int unsigned WORD_SHIFT      = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  input  logic                               loop_in,
  input  logic [ADDR_WIDTH-1:0]              base_addr_in,
  output logic                               req_valid_out,
  input  logic                               req_ready_in,
  output logic [ADDR_WIDTH-1:0]              req_addr_out,
  input  logic                               resp_valid_in,
  input  logic                               resp_ready_in,
  output logic                               last_data_out,
  output logic [$clog2(NUM_WORDS+1)-1:0]     resp_index_out,
  output logic                               busy_out,
  output logic                               done_out,
  output logic                               err_out
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]      resp_cnt_q, resp_cnt_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic req_fire;
  logic resp_fire;
  logic resp_ok;
  logic frame_end;

  // Request/response channel views derived from registered state
  assign busy_out       = (state_q != ST_IDLE);
  assign req_valid_out  = (state_q == ST_RUN) && (req_cnt_q < FRAME_LEN) &&
                          (outstanding_q < OUT_MAX);
  assign req_addr_out   = base_q + (ADDR_WIDTH'(req_cnt_q) << WORD_SHIFT);
  assign last_data_out  = busy_out && (resp_cnt_q == LAST_IDX);
  assign resp_index_out = resp_cnt_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

  assign req_fire  = req_valid_out && req_ready_in;
  assign resp_fire = resp_valid_in && resp_ready_in && busy_out;
  assign resp_ok   = resp_fire && (outstanding_q != '0);
  assign frame_end = resp_fire && last_data_out;

  // Next-state and counter update
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    outstanding_d = outstanding_q;
    base_d        = base_q;
    err_d         = err_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d       = ST_RUN;
          base_d        = base_addr_in;
          req_cnt_d     = '0;
          resp_cnt_d    = '0;
          outstanding_d = '0;
          err_d         = 1'b0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (req_fire) begin
          req_cnt_d = req_cnt_q + CNT_W'(1);
          if (req_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
        // A response with nothing in flight is flagged but never counted
        if (resp_fire) begin
          if (outstanding_q == '0) err_d = 1'b1;
          else                     resp_cnt_d = resp_cnt_q + CNT_W'(1);
        end
        outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(resp_ok);
        if (frame_end) begin
          done_d = 1'b1;
          if (loop_in) begin
            state_d       = ST_RUN;
            req_cnt_d     = '0;
            resp_cnt_d    = '0;
            outstanding_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      req_cnt_q     <= '0;
      resp_cnt_q    <= '0;
      outstanding_q <= '0;
      base_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_cnt_q     <= req_cnt_d;
      resp_cnt_q    <= resp_cnt_d;
      outstanding_q <= outstanding_d;
      base_q        <= base_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule
